// File: rtl/execute_bru_cond_pipe.sv
// Two-stage branch-condition resolver for the execute-stage BRU: S1 captures operands, S2 holds taken/mispredict.
// Optional mispredict perf counter enabled by defining EXECUTE_BRU_COND_PERFCNT_EN.
module execute_bru_cond_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [XLEN-1:0]  i_src0_value,
  input  logic [XLEN-1:0]  i_src1_value,
  input  logic [8:0]       i_bru_cmd,
  input  logic             i_pred_taken,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_taken,
  output logic             o_mispredict,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_mispredict_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [XLEN-1:0]  s1_src0_q, s1_src0_d;
  logic [XLEN-1:0]  s1_src1_q, s1_src1_d;
  logic [8:0]       s1_cmd_q, s1_cmd_d;
  logic             s1_pred_q, s1_pred_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_taken_q, s2_taken_d;
  logic             s2_mispred_q, s2_mispred_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic s2_free, s1_advance, in_hs, out_hs;
  logic src_ne, src_eq, src0_neg, src0_zero, src0_pos, src_slt, src_ult;
  logic taken;

  // o_ready sees only i_ready and stage state, never i_valid
  assign s2_free    = ~s2_valid_q | i_ready;
  assign s1_advance = s1_valid_q & s2_free;
  assign o_ready    = ~s1_valid_q | s1_advance;
  assign in_hs      = i_valid & o_ready;
  assign out_hs     = s2_valid_q & i_ready;

  assign src_ne    = (s1_src0_q != s1_src1_q);
  assign src_eq    = (s1_src0_q == s1_src1_q);
  assign src0_neg  = s1_src0_q[XLEN-1];
  assign src0_zero = (s1_src0_q == '0);
  assign src0_pos  = ~src0_neg & ~src0_zero;
  assign src_slt   = ($signed(s1_src0_q) < $signed(s1_src1_q));
  assign src_ult   = (s1_src0_q < s1_src1_q);

  // bit 5 is reserved and masked off; bit 6 is unconditional
  assign taken = |(s1_cmd_q & {src_ult, src_slt, 1'b1, 1'b0, src0_pos,
                               src0_zero, src0_neg, src_eq, src_ne});

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_src0_d  = s1_src0_q;
    s1_src1_d  = s1_src1_q;
    s1_cmd_d   = s1_cmd_q;
    s1_pred_d  = s1_pred_q;
    s1_tag_d   = s1_tag_q;
    if (in_hs) begin
      s1_src0_d = i_src0_value;
      s1_src1_d = i_src1_value;
      s1_cmd_d  = i_bru_cmd;
      s1_pred_d = i_pred_taken;
      s1_tag_d  = i_tag;
    end
    if (i_flush)         s1_valid_d = 1'b0;
    else if (in_hs)      s1_valid_d = 1'b1;
    else if (s1_advance) s1_valid_d = 1'b0;
  end

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_taken_d   = s2_taken_q;
    s2_mispred_d = s2_mispred_q;
    s2_tag_d     = s2_tag_q;
    if (s1_advance) begin
      s2_taken_d   = taken;
      s2_mispred_d = taken ^ s1_pred_q;
      s2_tag_d     = s1_tag_q;
    end
    if (i_flush)         s2_valid_d = 1'b0;
    else if (s1_advance) s2_valid_d = 1'b1;
    else if (out_hs)     s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid_q   <= 1'b0;
      s1_src0_q    <= '0;
      s1_src1_q    <= '0;
      s1_cmd_q     <= '0;
      s1_pred_q    <= 1'b0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_taken_q   <= 1'b0;
      s2_mispred_q <= 1'b0;
      s2_tag_q     <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_src0_q    <= s1_src0_d;
      s1_src1_q    <= s1_src1_d;
      s1_cmd_q     <= s1_cmd_d;
      s1_pred_q    <= s1_pred_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_taken_q   <= s2_taken_d;
      s2_mispred_q <= s2_mispred_d;
      s2_tag_q     <= s2_tag_d;
    end
  end

  assign o_valid      = s2_valid_q;
  assign o_taken      = s2_taken_q;
  assign o_mispredict = s2_mispred_q;
  assign o_tag        = s2_tag_q;

`ifdef EXECUTE_BRU_COND_PERFCNT_EN
  logic [31:0] mispredict_count_q, mispredict_count_d;

  // a handshake in a flush cycle was seen by the consumer, so it still counts
  always_comb begin
    mispredict_count_d = mispredict_count_q;
    if (out_hs && s2_mispred_q && !(&mispredict_count_q))
      mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) mispredict_count_q <= '0;
    else         mispredict_count_q <= mispredict_count_d;
  end

  assign o_mispredict_count = mispredict_count_q;
`else
  assign o_mispredict_count = '0;
`endif

endmodule

// File: doc/execute_bru_cond_pipe.md
# execute_bru_cond_pipe

Parametrised, pipelined branch-condition resolver for the execute-stage BRU. Evaluates a one-hot-style branch command against two XLEN-bit source operands, compares the outcome with the front-end prediction, and returns taken/mispredict with the instruction tag. Two registered stages behind a valid/ready handshake, with a synchronous flush. Sits between BRU issue and the redirect/commit logic.

## Interface
Parameters:
- XLEN, 32, operand width (≥ 2)
- TAG_W, 6, instruction tag width carried alongside the branch

Ports:
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  synchronous reset, active low
- i_flush  in  1  kill all in-flight entries this cycle
- i_valid  in  1  input entry valid
- o_ready  out  1  block can accept an input this cycle
- i_src0_value  in  XLEN  operand 0
- i_src1_value  in  XLEN  operand 1
- i_bru_cmd  in  9  branch command bits (see Operation)
- i_pred_taken  in  1  front-end predicted direction
- i_tag  in  TAG_W  instruction tag
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_taken  out  1  resolved direction
- o_mispredict  out  1  o_taken != predicted direction
- o_tag  out  TAG_W  tag of result
- o_mispredict_count  out  32  mispredict perf counter (see Configuration)

## Operation
- Command bits, OR-combined (multiple set bits → logical OR of conditions):
  - [0] src0 != src1; [1] src0 == src1; [2] signed src0 < 0; [3] src0 == 0; [4] signed src0 > 0; [5] reserved, ignored; [6] unconditional; [7] signed src0 < src1; [8] unsigned src0 < src1.
  - Command 0 → not taken.
- Comparisons are full XLEN; signed uses two's-complement of XLEN bits, no sign extension beyond XLEN.
- Stage S1: registers src0, src1, cmd, pred, tag on input handshake (i_valid & o_ready).
- Stage S2: registers o_taken, o_mispredict = taken ^ pred, tag, computed from S1 contents.
- Advance rules: S2 loads when S1 valid and (S2 empty or i_ready); S1 loads when input handshake. o_ready = ~s1_valid | s1_advance. Entries never reorder, never duplicate, never drop except on flush.
- Output handshake: o_valid & i_ready. o_valid/o_taken/o_mispredict/o_tag hold stable while o_valid & ~i_ready.
- Flush: i_flush clears S1 and S2 valid next edge; a simultaneous input handshake is discarded; a simultaneous output handshake completes (consumer saw it) but is not counted if flush is also asserted? No — it is counted: output handshake takes effect regardless of flush.
- Reset dominates flush.

## Timing
- Reset values: o_valid 0, o_taken 0, o_mispredict 0, o_tag 0, o_mispredict_count 0, both stage valids 0; o_ready 1 the cycle after reset release.
- Latency: input handshake at cycle N → o_valid at N+2 with i_ready held high.
- Throughput: one per cycle with i_ready high; with i_ready low, two entries buffered, then o_ready drops combinationally the cycle S1 cannot advance.
- o_ready depends combinationally on i_ready only (no input-to-ready path).
- Data fields of empty stages are don't-care but must not be X after reset (reset to 0).

## Configuration
- EXECUTE_BRU_COND_PERFCNT_EN defined: o_mispredict_count increments by 1 on each output handshake with o_mispredict = 1, saturating at 0xFFFF_FFFF; cleared only by reset.
- Undefined: counter logic absent, o_mispredict_count tied to 0; all other behaviour identical.

## Test plan
- Reset: hold resetn=0 3 cycles → o_valid=0, o_taken=0, o_tag=0, count=0; o_ready=1 after release.
- Command sweep XLEN=32: cmd bit7, src0=0xFFFF_FFFF, src1=1 → taken=1; cmd bit8 same operands → taken=0; cmd bit4 src0=0x8000_0000 → taken=0; cmd 0 → taken=0.
- Mispredict: cmd bit1, src0=src1=5, pred=0, tag=0x2A → two cycles later o_taken=1, o_mispredict=1, o_tag=0x2A; count 1 (macro defined) / 0 (undefined).
- Back-pressure: stream tags 1..4 back-to-back, i_ready=0 from cycle 2 for 4 cycles → o_ready falls after 2 entries buffered, outputs stable; release → tags 1,2,3,4 in order, none lost.
- Flush: two entries in flight plus input handshake in flush cycle → next cycle o_valid=0, dropped tags never appear.
- Saturation (macro defined, force counter 0xFFFF_FFFE): three mispredicting outputs → count ends 0xFFFF_FFFF.
